i2c_bus_monitor: RTL
====================

Name: i2c_bus_monitor

Overview:
Parametrised successor to the I2C master's bus-busy detector. Watches synchronised SDA/SCL and decodes START, repeated START and STOP. Tracks bus ownership and enforces a programmable bus-free hold-off after STOP. Adds an SMBus-style SCL-low timeout; the master and slave FSMs consume its busy/available/timeout outputs.

Parameters:
CNT_W, 16, width of hold-off and timeout counters and of their configuration inputs

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
SDA_sync  input  1  synchronised SDA
SCL_sync  input  1  synchronised SCL
bus_free_cycles  input  CNT_W  idle clk cycles required after STOP before bus_available (0 = none)
scl_low_timeout  input  CNT_W  consecutive SCL-low cycles while busy that trigger timeout (0 = disabled)
clear_timeout  input  1  clears timeout_flag
start_det  output  1  one-cycle pulse: START from not-busy
rstart_det  output  1  one-cycle pulse: START while busy
stop_det  output  1  one-cycle pulse: STOP detected
bus_busy  output  1  bus owned (START seen, no STOP/timeout yet)
bus_available  output  1  bus idle and hold-off complete
timeout_pulse  output  1  one-cycle pulse when SCL-low timeout fires
timeout_flag  output  1  sticky timeout indication

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on n_rst.
- Reset values: sda_q=1, scl_q=1, state IDLE, counters 0, all pulses 0, bus_busy=0, bus_available=1, timeout_flag=0.
- Sampling: sda_q/scl_q hold the previous-cycle SDA_sync/SCL_sync.
- START condition: scl_q=1, SCL_sync=1, sda_q=1, SDA_sync=0.
- STOP condition: scl_q=1, SCL_sync=1, sda_q=0, SDA_sync=1.
- An SDA change in the same cycle that SCL changes is neither START nor STOP.
- Latency: all outputs are registered and update on the first rising clk edge at which the condition is present at the inputs. An SDA fall applied after a negedge is therefore visible at the next negedge.
- States: IDLE, BUSY, HOLDOFF.
  - IDLE: bus_busy=0, bus_available=1. START -> BUSY with start_det. STOP -> stop_det pulse, stay IDLE (spurious STOP).
  - BUSY: bus_busy=1, bus_available=0. START -> rstart_det, stay BUSY, reset the SCL-low counter. STOP -> stop_det, then go to HOLDOFF and clear hold_cnt, or go directly to IDLE if bus_free_cycles=0. SDA/SCL activity that is not START/STOP never changes bus_busy.
  - HOLDOFF: bus_busy=0, bus_available=0. hold_cnt increments each cycle; when hold_cnt+1 >= bus_free_cycles -> IDLE. START -> BUSY with start_det (another master took the bus). STOP -> stop_det and restart the count.
- SCL-low timeout: active in BUSY only, and only when scl_low_timeout≠0. low_cnt increments each cycle SCL_sync=0 and clears when SCL_sync=1.
  - When low_cnt+1 = scl_low_timeout: timeout_pulse=1 and timeout_flag=1. State then goes to HOLDOFF (or IDLE if bus_free_cycles=0) and low_cnt clears.
  - low_cnt saturates at all-ones and never wraps.
- timeout_flag is sticky. clear_timeout clears it; a new timeout firing in the same cycle as clear_timeout wins (flag stays 1).
- Configuration inputs are sampled every cycle. Changing them mid-count compares the running count against the new value.
- Reset mid-transfer returns to IDLE immediately. The monitor then treats the bus as free until the next START, even if SDA/SCL are low.
- Pulses never overlap except timeout_pulse, which cannot coincide with START/STOP because SCL is low.

Decomposition:
- Package i2c_pkg: typedef enum logic [1:0] monitor_state_t {IDLE, BUSY, HOLDOFF}; localparam default CNT_W.
- Sub-module i2c_cond_detect: holds sda_q/scl_q and emits combinational start_cond/stop_cond. It is reusable by the slave.
- FSM and counters stay in i2c_bus_monitor.

Test Plan:
- Reset with SDA=SCL=1, then 3 idle cycles -> bus_busy=0, bus_available=1, no pulses.
- SDA 1->0 with SCL=1 -> start_det=1 for exactly one cycle; bus_busy=1 at the next negedge; SCL falls -> bus_busy stays 1.
- Six data bits 0,1,0,0,1,1 with SDA changing only while SCL=0 -> bus_busy constant 1, no start/stop pulses.
- Repeated START (SDA high, SCL high, SDA falls) while busy -> rstart_det single pulse, start_det=0, bus_busy stays 1.
- STOP with bus_free_cycles=4:
  - bus_busy=0 the cycle after STOP;
  - bus_available=0 for 4 cycles, then 1;
  - repeat with a START inserted at hold-off cycle 2 -> start_det pulse, BUSY, bus_available never rises.
- scl_low_timeout=10, bus busy, SCL held low 10 cycles:
  - timeout_pulse on cycle 10, timeout_flag=1, bus_busy=0;
  - clear_timeout -> flag 0;
  - with scl_low_timeout=0, SCL low 1000 cycles -> no timeout.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C bus monitor and condition detector.
package i2c_pkg;

    // Default width of the hold-off/timeout counters and their config inputs.
    localparam int CNT_W_DEFAULT = 16;

    // Bus ownership as seen by the monitor.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLDOFF = 2'd2
    } monitor_state_t;

endpackage : i2c_pkg

// File: rtl/i2c_cond_detect.sv
// START/STOP condition detector on synchronised SDA/SCL.
// Keeps the previous-cycle line levels and flags an SDA edge while SCL stays
// high in both cycles; an SDA change alongside an SCL change is ignored.
module i2c_cond_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic SDA_sync,
    input  logic SCL_sync,
    output logic start_cond,
    output logic stop_cond
);

    logic sda_q;
    logic scl_q;

    // Previous-cycle line levels; idle bus (both high) after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= SDA_sync;
            scl_q <= SCL_sync;
        end
    end

    // SDA falling / rising while SCL is high across both samples.
    always_comb begin
        start_cond = scl_q & SCL_sync & sda_q & ~SDA_sync;
        stop_cond  = scl_q & SCL_sync & ~sda_q & SDA_sync;
    end

endmodule : i2c_cond_detect

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: decodes START / repeated START / STOP, tracks bus
// ownership, enforces a bus-free hold-off after STOP and raises an
// SMBus-style SCL-low timeout while the bus is owned.
//
// Line interface: SDA_sync/SCL_sync are already synchronised to clk.
// All outputs are registered; pulses last exactly one clk cycle.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             SDA_sync,
    input  logic             SCL_sync,
    input  logic [CNT_W-1:0] bus_free_cycles,
    input  logic [CNT_W-1:0] scl_low_timeout,
    input  logic             clear_timeout,
    output logic             start_det,
    output logic             rstart_det,
    output logic             stop_det,
    output logic             bus_busy,
    output logic             bus_available,
    output logic             timeout_pulse,
    output logic             timeout_flag
);

    monitor_state_t   state, state_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [CNT_W-1:0] low_cnt, low_n;
    logic [CNT_W:0]   hold_inc, low_inc;
    logic             start_cond, stop_cond;
    logic             start_n, rstart_n, stop_n, fire;

    i2c_cond_detect u_cond (
        .clk        (clk),
        .n_rst      (n_rst),
        .SDA_sync   (SDA_sync),
        .SCL_sync   (SCL_sync),
        .start_cond (start_cond),
        .stop_cond  (stop_cond)
    );

    // One extra bit so count+1 never wraps before comparison.
    assign hold_inc = {1'b0, hold_cnt} + (CNT_W+1)'(1);
    assign low_inc  = {1'b0, low_cnt} + (CNT_W+1)'(1);

    // State, counters and registered pulses/flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            low_cnt       <= '0;
            start_det     <= 1'b0;
            rstart_det    <= 1'b0;
            stop_det      <= 1'b0;
            timeout_pulse <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_n;
            low_cnt       <= low_n;
            start_det     <= start_n;
            rstart_det    <= rstart_n;
            stop_det      <= stop_n;
            timeout_pulse <= fire;
            // A timeout firing together with a clear leaves the flag set.
            timeout_flag  <= fire | (timeout_flag & ~clear_timeout);
        end
    end

    // Next state, counter updates and pulse requests.
    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        low_n    = low_cnt;
        start_n  = 1'b0;
        rstart_n = 1'b0;
        stop_n   = 1'b0;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                hold_n = '0;
                low_n  = '0;
                if (start_cond) begin
                    state_n = BUSY;
                    start_n = 1'b1;
                end else if (stop_cond) begin
                    stop_n = 1'b1;   // spurious STOP, bus stays free
                end
            end
            BUSY: begin
                hold_n = '0;
                if (start_cond) begin
                    rstart_n = 1'b1;
                    low_n    = '0;
                end else if (stop_cond) begin
                    stop_n  = 1'b1;
                    low_n   = '0;
                    state_n = (bus_free_cycles == '0) ? IDLE : HOLDOFF;
                end else if (SCL_sync) begin
                    low_n = '0;
                end else if ((scl_low_timeout != '0) &&
                             (low_inc == {1'b0, scl_low_timeout})) begin
                    fire    = 1'b1;
                    low_n   = '0;
                    state_n = (bus_free_cycles == '0) ? IDLE : HOLDOFF;
                end else if (!(&low_cnt)) begin
                    low_n = low_inc[CNT_W-1:0];   // saturates at all-ones
                end
            end
            HOLDOFF: begin
                low_n = '0;
                if (start_cond) begin
                    state_n = BUSY;   // another master took the bus
                    start_n = 1'b1;
                    hold_n  = '0;
                end else if (stop_cond) begin
                    stop_n = 1'b1;
                    hold_n = '0;
                end else if (hold_inc >= {1'b0, bus_free_cycles}) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else begin
                    hold_n = hold_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_n = IDLE;
                hold_n  = '0;
                low_n   = '0;
            end
        endcase
    end

    // Level outputs decoded from the registered state.
    always_comb begin
        bus_busy      = (state == BUSY);
        bus_available = (state == IDLE);
    end

endmodule : i2c_bus_monitor
